// File: rtl/replay_buffer.sv
// replay_buffer
//   Stream expander. During the first pass it pops one group-wide word per
//   issue from a small input FIFO, stores it in local memory at the current
//   word index and forwards it downstream. On every later pass the stored
//   words are replayed from memory in the same order, so downstream sees the
//   same num_reads_per_iter words num_iters times.
//
// Ports
//   clk                 clock
//   rst                 synchronous reset, active low
//   configure           one-cycle pulse: loads counts and enables the block
//   num_iters           total passes, the capture pass included
//   num_reads_per_iter  words per pass
//   data_in/valid_in    input word stream (2-slot FIFO in front)
//   avail_out           block can accept an input word
//   data_out/valid_out  output word stream, two cycles after issue
//   avail_in            downstream can accept; no issue while low
//   busy                enabled or words still in the output pipeline
module replay_buffer #(
  parameter int DATA_WIDTH             = 8,
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 12,
  parameter int NUM_ADDRESSES          = 4096,
  parameter int LOG_MAX_ADDRESS        = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_in,
  input  logic                              valid_in,
  output logic                              avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_out,
  output logic                              valid_out,
  input  logic                              avail_in,
  output logic                              busy
);

  localparam int W = GROUP_SIZE * DATA_WIDTH;

  // ---------------------------------------------------------------
  // Input FIFO (2 slots)
  // ---------------------------------------------------------------
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       fifo_full;
  logic       fifo_almost_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic [W-1:0] fifo_head;

  assign fifo_full        = (count_reg == 2'd2);
  assign fifo_almost_full = (count_reg == 2'd1);
  assign fifo_empty       = (count_reg == 2'd0);
  // Deasserting while one slot is used leaves room for the one word
  // upstream may still send in the cycle after avail_out falls.
  assign avail_out        = ~fifo_full & ~fifo_almost_full;
  // A word arriving while full is a protocol violation and is dropped.
  assign push             = valid_in & ~fifo_full;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [W-1:0] slot_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == gi[0])) begin
          slot_reg <= data_in;
        end
      end
    end
  endgenerate

  assign fifo_head  = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------
  // Pass / word control
  // ---------------------------------------------------------------
  logic [LOG_MAX_ITERS-1:0]          iter_cnt_reg;
  logic [LOG_MAX_READS_PER_ITER-1:0] word_cnt_reg;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_m1_reg;
  logic                              first_reg;
  logic                              enabled_reg;
  logic                              issue;
  logic                              last_word;
  logic [LOG_MAX_ADDRESS-1:0]        addr;

  // The capture pass needs an input word; replay passes only need room
  // downstream. Nothing issues in a configure cycle so that the freshly
  // loaded counters are the ones the first issue sees.
  assign issue = enabled_reg & avail_in & ~configure & (~first_reg | ~fifo_empty);
  assign pop   = issue & first_reg;
  assign last_word = (word_cnt_reg == reads_m1_reg);
  assign addr  = LOG_MAX_ADDRESS'(word_cnt_reg);

  always_ff @(posedge clk) begin
    if (!rst) begin
      iter_cnt_reg <= '0;
      word_cnt_reg <= '0;
      reads_m1_reg <= '0;
      first_reg    <= 1'b0;
      enabled_reg  <= 1'b0;
    end else if (configure) begin
      iter_cnt_reg <= num_iters;
      word_cnt_reg <= '0;
      reads_m1_reg <= num_reads_per_iter - 1'b1;
      first_reg    <= 1'b1;
      enabled_reg  <= (num_iters != '0) && (num_reads_per_iter != '0);
    end else if (issue) begin
      if (last_word) begin
        word_cnt_reg <= '0;
        first_reg    <= 1'b0;
        if (iter_cnt_reg == LOG_MAX_ITERS'(1)) begin
          enabled_reg <= 1'b0;
        end else begin
          iter_cnt_reg <= iter_cnt_reg - 1'b1;
        end
      end else begin
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Word memory: written during the capture pass, read with a
  // registered port afterwards. Writes and reads never target the same
  // cycle, and a read one cycle after a write to the same address sees
  // the new word because the write has already committed.
  // ---------------------------------------------------------------
  logic [W-1:0] mem [NUM_ADDRESSES];
  logic [W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (pop) begin
      mem[addr] <= fifo_head;
    end
    if (issue && !first_reg) begin
      rd_data_reg <= mem[addr];
    end
  end

  // ---------------------------------------------------------------
  // Output pipeline: stage 1 picks bypass or memory data, stage 2 is
  // the output register. It never stalls; downstream absorbs the words
  // already in flight when it drops avail_in.
  // ---------------------------------------------------------------
  logic [W-1:0] bypass_reg;
  logic         stage1_valid_reg;
  logic         stage1_first_reg;
  logic [W-1:0] stage1_data;
  logic [W-1:0] data_out_reg;
  logic         valid_out_reg;

  assign stage1_data = stage1_first_reg ? bypass_reg : rd_data_reg;

  always_ff @(posedge clk) begin
    if (pop) begin
      bypass_reg <= fifo_head;
    end
    if (issue) begin
      stage1_first_reg <= first_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage1_valid_reg <= 1'b0;
      valid_out_reg    <= 1'b0;
      data_out_reg     <= '0;
    end else if (configure) begin
      stage1_valid_reg <= 1'b0;
      valid_out_reg    <= 1'b0;
    end else begin
      stage1_valid_reg <= issue;
      valid_out_reg    <= stage1_valid_reg;
      if (stage1_valid_reg) begin
        data_out_reg <= stage1_data;
      end
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign busy      = enabled_reg | stage1_valid_reg | valid_out_reg;

endmodule

// File: tb/tb_replay_buffer.sv
module tb_replay_buffer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          configure;
  logic [15:0]   num_iters;
  logic [11:0]   num_reads_per_iter;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic          avail_out;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          avail_in;
  logic          busy;

  replay_buffer dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .data_in            (data_in),
    .valid_in           (valid_in),
    .avail_out          (avail_out),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .avail_in           (avail_in),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];    // scoreboard: expected output words in order
  logic [W-1:0] model_q[$];  // words the model believes sit in the input FIFO
  logic [W-1:0] stim_q[$];   // words to send for the next test
  int           vo_times[$]; // cycle numbers of valid_out in the current test
  int           seen = 0;
  int           first_send = 0;
  logic         ain_d1 = 1'b1;
  logic         ain_d2 = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no word (cycle %0d)", data_out, cyc);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          $display("out cycle %0d data %h expected %h", cyc, data_out, e);
          check("data_out", 64'(data_out), 64'(e));
        end
        // A word on the output means an issue two cycles earlier, which is
        // only legal while downstream had avail_in high.
        check("issue_while_avail_in_low", 64'(ain_d2), 64'(1));
        seen++;
        vo_times.push_back(cyc);
      end
      ain_d2 = ain_d1;
      ain_d1 = avail_in;
    end
  end

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back($urandom());
  endtask

  // Runs one configuration. amode 0: avail_in always 1; 1: fixed toggle
  // pattern then random. gap: minimum cycles between input words.
  // abort_at > 0: pulse reset once that many words were observed.
  task automatic run_test(input int n_it, input int n_rd, input int gap,
                          input int amode, input int abort_at);
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int sent = 0;
    int last_send = -100;
    logic prev_avail;
    bit done = 0;

    // Reference model: the pass sees the first n_rd words of the input
    // stream and repeats them n_it times.
    foreach (stim_q[i]) model_q.push_back(stim_q[i]);
    if (n_it != 0 && n_rd != 0) begin
      logic [W-1:0] grp[$];
      for (int i = 0; i < n_rd; i++) grp.push_back(model_q.pop_front());
      for (int k = 0; k < n_it; k++)
        foreach (grp[i]) exp_q.push_back(grp[i]);
    end
    vo_times.delete();
    seen = 0;
    $display("test iters=%0d reads=%0d words=%0d gap=%0d amode=%0d", n_it, n_rd, stim_q.size(), gap, amode);

    num_iters = 16'(n_it);
    num_reads_per_iter = 12'(n_rd);
    configure = 1'b1;
    @(posedge clk); #1;
    configure = 1'b0;
    prev_avail = avail_out;

    for (int c = 0; c < 3000 && !done; c++) begin
      avail_in = (amode == 0) ? 1'b1 : (c < 6 ? pat[c][0] : 1'($urandom_range(0, 1)));
      valid_in = 1'b0;
      if (sent < stim_q.size() && (avail_out || prev_avail) && (cyc - last_send >= gap)) begin
        valid_in = 1'b1;
        data_in = stim_q[sent];
        if (sent == 0) first_send = cyc;
        sent++;
        last_send = cyc;
      end
      prev_avail = avail_out;
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (abort_at > 0 && seen >= abort_at) begin
        rst = 1'b0;
        avail_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        model_q.delete();
        check("abort_valid_out", 64'(valid_out), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_avail_out", 64'(avail_out), 64'(1));
        return;
      end
      if (sent == stim_q.size() && exp_q.size() == 0) done = 1;
    end
    avail_in = 1'b1;

    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d words pending expected 0", exp_q.size());
      exp_q.delete();
    end else if (n_it != 0 && n_rd != 0) begin
      // One cycle after the final word the pipeline is drained.
      check("busy_after_drain", 64'(busy), 64'(0));
      check("output_count", 64'(vo_times.size()), 64'(n_it * n_rd));
    end
  endtask

  initial begin
    rst = 1'b0;
    configure = 1'b0;
    num_iters = '0;
    num_reads_per_iter = '0;
    data_in = '0;
    valid_in = 1'b0;
    avail_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset_valid_out", 64'(valid_out), 64'(0));
    check("reset_data_out", 64'(data_out), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_avail_out", 64'(avail_out), 64'(1));

    // Three passes of four words.
    stim_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_test(3, 4, 1, 0, 0);
    if (vo_times.size() > 0)
      check("first_latency", 64'(vo_times[0] - first_send), 64'(3));

    // Single pass: nothing is replayed.
    stim_q = '{32'h11, 32'h22};
    run_test(1, 2, 1, 0, 0);
    repeat (6) @(posedge clk);
    #1;

    // One word replayed four times back to back (read after write).
    stim_q = '{32'h12345678};
    run_test(4, 1, 1, 0, 0);
    for (int i = 1; i < vo_times.size(); i++)
      check("raw_spacing", 64'(vo_times[i] - vo_times[i-1]), 64'(1));

    // Downstream toggling avail_in.
    fill_random(3);
    run_test(2, 3, 1, 1, 0);

    // Sparse input: capture pass spaced by 3, replay back to back.
    fill_random(4);
    run_test(2, 4, 3, 0, 0);
    for (int i = 1; i < vo_times.size(); i++)
      check("sparse_spacing", 64'(vo_times[i] - vo_times[i-1]), 64'((i < 4) ? 3 : 1));

    // Reset in the middle of pass 2, then a fresh one-word run.
    fill_random(4);
    run_test(3, 4, 1, 0, 6);
    stim_q = '{32'h55};
    run_test(1, 1, 1, 0, 0);

    // num_iters == 0: block stays idle, input words stay buffered.
    fill_random(2);
    run_test(0, 2, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("zero_iters_busy", 64'(busy), 64'(0));
      check("zero_iters_valid", 64'(valid_out), 64'(0));
      @(posedge clk); #1;
    end
    check("zero_iters_buffered", 64'(avail_out), 64'(0));
    stim_q.delete();
    run_test(1, 2, 1, 0, 0);

    // Randomized configurations.
    for (int t = 0; t < 6; t++) begin
      int n_it;
      int n_rd;
      n_it = $urandom_range(1, 3);
      n_rd = $urandom_range(1, 5);
      fill_random(n_rd);
      run_test(n_it, n_rd, $urandom_range(1, 2), $urandom_range(0, 1), 0);
    end

    repeat (6) @(posedge clk);
    #1;
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/replay_buffer.md
Name: replay_buffer

Overview:
- Stream expander; the inverse of the accumulate stage, which reduces N iterations into one output.
- Iteration 1: captures one group-wide input stream of num_reads_per_iter words into local memory and forwards each word downstream.
- Iterations 2..num_iters: replays the stored words from memory in the same order.
- Sits in front of compute stages that consume the same data once per output-channel pass.

Parameters:
DATA_WIDTH, 8, item width
GROUP_SIZE, 4, items per word (word width W = GROUP_SIZE*DATA_WIDTH)
LOG_MAX_ITERS, 16, width of num_iters
LOG_MAX_READS_PER_ITER, 12, width of num_reads_per_iter
NUM_ADDRESSES, 4096, memory depth; must be >= max num_reads_per_iter
LOG_MAX_ADDRESS, 12, address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
configure  in  1  one-cycle pulse; loads counts, enables block
num_iters  in  LOG_MAX_ITERS  total passes (iteration 1 included)
num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  words per pass
data_in  in  W  input word
valid_in  in  1  input word valid
avail_out  out  1  block can accept input
data_out  out  W  output word
valid_out  out  1  output word valid
avail_in  in  1  downstream can accept
busy  out  1  enabled or words still in pipeline

Behaviour:
- Reset (rst=0 at clk edge):
  - Counters cleared, enabled=0, pipeline valid bits cleared, input FIFO emptied.
  - Outputs: valid_out=0, data_out=0, busy=0, avail_out=1 (from cycle after reset).
  - Reset mid-operation aborts all activity; memory contents undefined afterwards.
- Input side:
  - 2-slot input FIFO; avail_out = ~full & ~almost_full (almost_full = 1 slot used).
  - Upstream may issue one word in the cycle after avail_out falls.
  - valid_in while full is a protocol violation; the word is dropped.
- Configure:
  - Loads iter_cnt=num_iters, word_cnt=0, iteration index first=1, enabled=1.
  - Squashes pipeline valid bits. FIFO contents are kept.
  - If num_iters==0 or num_reads_per_iter==0: enabled stays 0, no output.
- Issue condition (cycle t):
  - Iteration 1: issue = enabled & avail_in & ~fifo_empty. Pops FIFO, writes the popped word to mem[word_cnt] at edge t, and captures it into the bypass register.
  - Iterations >1: issue = enabled & avail_in. Registered read of mem[word_cnt] issued at t.
  - No issue means all counters hold (stall).
- Counters, on issue:
  - If word_cnt == num_reads_per_iter-1: word_cnt=0, first=0.
    - If iter_cnt==1: enabled=0.
    - Else: iter_cnt decrements.
  - Otherwise word_cnt increments.
- Latency and ordering:
  - Each issued word appears with valid_out=1 at cycle t+2 in every iteration.
  - Stage 1 selects the bypass register (iteration 1) or memory read data (later iterations); stage 2 is the output register.
  - Output order is address 0..num_reads_per_iter-1 every pass.
  - Total valid_out count = num_iters*num_reads_per_iter.
- Read-after-write: with num_reads_per_iter==1, the iteration-2 read of addr 0 at t+1 must return the word written at edge t. The write commits before the read.
- Downstream protocol: deasserting avail_in obliges downstream to absorb up to 2 words already in flight. The block never issues while avail_in=0.
- data_out holds its last value when valid_out=0.
- busy = enabled | stage1_valid | stage2_valid; falls 2 cycles after the final issue.
- Input words beyond num_reads_per_iter stay in the FIFO for the next configuration.

Test Plan:
- num_iters=3, reads=4, inputs 0xA0..0xA3 back-to-back, avail_in=1 -> data_out sequence A0,A1,A2,A3 repeated 3 times, 12 valid cycles, first valid 2 cycles after first pop, busy=0 two cycles after last issue.
- num_iters=1, reads=2, inputs 0x11,0x22 -> exactly 2 output words 0x11,0x22; nothing written out again.
- num_iters=4, reads=1, input 0x12345678 -> 0x12345678 on 4 consecutive valid_out cycles (checks read-after-write).
- num_iters=2, reads=3, avail_in toggled 1,0,0,1,0,1,… -> no loss or duplication, order preserved, counters frozen while avail_in=0, at most 2 valids after an avail_in fall.
- num_iters=2, reads=4, valid_in only every third cycle -> iteration-1 outputs spaced 3 cycles apart, iteration-2 outputs back-to-back.
- Reset asserted mid iteration 2 of (3,4) -> next cycle valid_out=0, busy=0, avail_out=1; a following configure (1,1) with input 0x55 outputs 0x55 once.
- Configure with num_iters=0 -> busy stays 0, no valid_out, input data remains buffered.
